complex_div: RTL
================

Name: complex_div

Overview:
- Sequential fixed-point complex divider, c = a / b. It is the inverse operation of the team's combinational complex multiplier.
- Sits in the same DSP datapath, e.g. equalizer or channel-inverse stages.
- Valid/ready handshake on both sides; one operation in flight; iterative, one quotient bit per cycle.
- Operands and results are signed two's-complement Q1.(DATA_WIDTH-1).

Parameters:
DATA_WIDTH, 16, width of each real/imag component; fraction bits F = DATA_WIDTH-1

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
in_valid_i  input  1  operand valid
in_ready_o  output  1  block idle, can accept
a_re_i  input  DATA_WIDTH  dividend real, signed Q1.F
a_im_i  input  DATA_WIDTH  dividend imag
b_re_i  input  DATA_WIDTH  divisor real
b_im_i  input  DATA_WIDTH  divisor imag
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts result
c_re_o  output  DATA_WIDTH  quotient real, signed Q1.F
c_im_o  output  DATA_WIDTH  quotient imag
div_zero_o  output  1  divisor was 0+0i
ovf_o  output  1  re or im result saturated

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state IDLE, in_ready_o=1, out_valid_o=0, c_re_o=c_im_o=0, div_zero_o=0, ovf_o=0.
- Reset mid-operation: the operation is discarded with no output. The next cycle is IDLE.
- Math, exact integer arithmetic:
  - nr = ar*br + ai*bi
  - ni = ai*br - ar*bi
  - d = br^2 + bi^2
  - Signed products are 2W bits; sums are 2W+1 bits; d is unsigned.
  - Result component = sign(n) * floor(|n| * 2^F / d). Truncation is toward zero.
- States:
  - IDLE: in_ready_o=1. When in_valid_i&in_ready_o, register operands and go to LOAD.
  - LOAD: compute nr, ni, d.
    - If d==0: c_re_o=c_im_o=0, div_zero_o=1, ovf_o=0, go to DONE.
    - Otherwise, per component, pre-check |n|*2^F >= d*2^W. If true, that component is flagged overflow and its divider result is ignored.
    - Load both dividers, set count=W-1, go to DIV.
  - DIV: both dividers produce one quotient bit MSB-first per cycle. When count==0, go to DONE. In that transition, register the finals:
    - Apply sign.
    - Saturate: magnitude > 2^F-1 when positive, or > 2^F when negative, or pre-check flagged, gives 0x7FFF..F or 0x800..0 respectively.
    - ovf_o=OR of both components' saturation.
    - div_zero_o=0.
  - DONE: out_valid_o=1; outputs held stable. When out_ready_i=1, go to IDLE with out_valid_o=0 next cycle.
- Latency, counted in cycles from the accepting edge to out_valid_o high:
  - Normal: W+1 (17 at W=16).
  - d==0: 2.
- No accept while busy: in_ready_o=0 in LOAD, DIV and DONE. In_valid_i is ignored there.
- Back-to-back: the earliest next accept is the cycle after the DONE handshake.
- Both components always complete in the same cycle.

Optional Feature:
- Macro COMPLEX_DIV_ROUND_EN.
- When defined:
  - Dividers produce W+1 bits; the extra LSB is the half bit.
  - Magnitude = (q>>1) + q[0], i.e. round half away from zero, applied before saturation.
  - Normal latency becomes W+2.
- When undefined: truncation as above, latency W+1.

Decomposition:
- Package complex_div_pkg:
  - state enum {IDLE, LOAD, DIV, DONE}.
  - Localparams for product/sum widths (2W, 2W+1), saturation constants, and quotient bit count (W, or W+1 under the macro).
- Sub-module complex_div_serial_div, instantiated twice (re, im):
  - Unsigned restoring divider with start/load inputs and a 1 bit/cycle step.
  - Remainder and quotient shift registers.
  - Exposes quotient.

Test Plan:
- a=(8192,0), b=(16384,0) -> c=(16384,0), ovf=0, div_zero=0, out_valid exactly 17 cycles after accept.
- a=(8192,0), b=(0,16384) -> c=(0,-16384 i.e. 0xC000); a=(8192,8192), b=(16384,16384) -> c=(16384,0).
- b=(0,0), any a -> c=(0,0), div_zero=1, out_valid 2 cycles after accept; next op is normal with div_zero=0.
- Overflow: a=(16384,0), b=(8192,0) -> c_re=32767, ovf=1; a=(-16384,0), b=(8192,0) -> c_re=-32768, ovf=1.
- Rounding: a=(1,0), b=(3,0) -> c_re=10922 without COMPLEX_DIV_ROUND_EN, 10923 with it (latency 18).
- Backpressure and reset:
  - Hold out_ready_i=0 for 5 cycles in DONE: outputs stable, in_ready_o=0, new in_valid_i ignored.
  - Assert rst_i mid-DIV: no out_valid, all outputs at reset values, in_ready_o=1 next cycle.

Source files
------------

// File: rtl/complex_div_pkg.sv
// Shared state type and width helpers for the sequential complex divider.
// Defining COMPLEX_DIV_ROUND_EN adds a half bit so results round half away from zero.
package complex_div_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

`ifdef COMPLEX_DIV_ROUND_EN
  localparam int Q_EXTRA = 1;
`else
  localparam int Q_EXTRA = 0;
`endif

  function automatic int prodWidth(input int w);
    return 2 * w;
  endfunction

  function automatic int sumWidth(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int quotBits(input int w);
    return w + Q_EXTRA;
  endfunction

endpackage

// File: rtl/complex_div_serial_div.sv
// Unsigned restoring divider: one quotient bit per step, MSB first.
module complex_div_serial_div #(
  parameter int DW = 33,
  parameter int QW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [DW-1:0] remInit,
  input  logic [QW-1:0] shiftIn,
  input  logic [DW-1:0] divisor,
  output logic [QW-1:0] quotient
);

  logic [DW-1:0] rem;
  logic [QW-1:0] pending;
  logic [QW-1:0] qReg;
  logic [DW:0]   trial;
  logic [DW:0]   diff;
  logic [DW-1:0] remNext;
  logic          qBit;
  logic          unusedDiffMsb;

  // Trial subtraction for the current step. The quotient output already includes
  // the bit being resolved now, so the owner can capture it on the final step edge.
  always_comb begin
    trial         = {rem, pending[QW-1]};
    diff          = trial - {1'b0, divisor};
    qBit          = (trial >= {1'b0, divisor});
    remNext       = qBit ? diff[DW-1:0] : trial[DW-1:0];
    unusedDiffMsb = diff[DW];
    quotient      = {qReg[QW-2:0], qBit};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem     <= '0;
      pending <= '0;
      qReg    <= '0;
    end else if (load) begin
      rem     <= remInit;
      pending <= shiftIn;
      qReg    <= '0;
    end else if (step) begin
      rem     <= remNext;
      pending <= {pending[QW-2:0], 1'b0};
      qReg    <= quotient;
    end
  end

endmodule

// File: rtl/complex_div.sv
// Sequential fixed-point complex divider c = a / b, Q1.(DATA_WIDTH-1), one bit per cycle.
// Optional rounding via COMPLEX_DIV_ROUND_EN (see complex_div_pkg).
module complex_div
  import complex_div_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] a_re_i,
  input  logic [DATA_WIDTH-1:0] a_im_i,
  input  logic [DATA_WIDTH-1:0] b_re_i,
  input  logic [DATA_WIDTH-1:0] b_im_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] c_re_o,
  output logic [DATA_WIDTH-1:0] c_im_o,
  output logic                  div_zero_o,
  output logic                  ovf_o
);

  localparam int W      = DATA_WIDTH;
  localparam int PROD_W = prodWidth(W);
  localparam int SUM_W  = sumWidth(W);
  localparam int QBITS  = quotBits(W);
  localparam int CNT_W  = $clog2(QBITS + 1);
  localparam logic [W-1:0] SAT_MAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN   = {1'b1, {(W-1){1'b0}}};
  localparam logic [W:0]   NEG_LIMIT = {2'b01, {(W-1){1'b0}}};

  state_t state, nextState;
  logic signed [W-1:0] aRe, aIm, bRe, bIm;
  logic signed [PROD_W-1:0] pArBr, pAiBi, pAiBr, pArBi, pBrBr, pBiBi;
  logic signed [SUM_W-1:0] nRe, nIm;
  logic [SUM_W-1:0] dSum, absRe, absIm;
  logic preRe, preIm;
  logic [QBITS-1:0] qRe, qIm;
  logic [CNT_W-1:0] count;
  logic negRe, negIm, preOvfRe, preOvfIm, zeroDiv;
  logic loadDiv, stepDiv;
  logic [W:0] finRe, finIm;
  logic [W-1:0] cRe, cIm;
  logic divZeroR, ovfR;

  // Sign, optional half-bit rounding and saturation of one quotient; returns {sat, value}.
  function automatic logic [W:0] finalize(input logic [QBITS-1:0] q, input logic neg,
                                          input logic preOvf);
    logic [W:0]   mag;
    logic         sat;
    logic [W-1:0] val;
`ifdef COMPLEX_DIV_ROUND_EN
    mag = (q >> 1) + {{W{1'b0}}, q[0]};
`else
    mag = {1'b0, q};
`endif
    sat = preOvf || (neg ? (mag > NEG_LIMIT) : (mag > {1'b0, SAT_MAX}));
    val = sat ? (neg ? SAT_MIN : SAT_MAX) : (neg ? -mag[W-1:0] : mag[W-1:0]);
    return {sat, val};
  endfunction

  // Exact numerators and denominator from the registered operands (stable until IDLE).
  always_comb begin
    pArBr = PROD_W'(aRe) * PROD_W'(bRe);
    pAiBi = PROD_W'(aIm) * PROD_W'(bIm);
    pAiBr = PROD_W'(aIm) * PROD_W'(bRe);
    pArBi = PROD_W'(aRe) * PROD_W'(bIm);
    pBrBr = PROD_W'(bRe) * PROD_W'(bRe);
    pBiBi = PROD_W'(bIm) * PROD_W'(bIm);
    nRe   = {pArBr[PROD_W-1], pArBr} + {pAiBi[PROD_W-1], pAiBi};
    nIm   = {pAiBr[PROD_W-1], pAiBr} - {pArBi[PROD_W-1], pArBi};
    dSum  = {1'b0, pBrBr} + {1'b0, pBiBi};
    absRe = nRe[SUM_W-1] ? -nRe : nRe;
    absIm = nIm[SUM_W-1] ? -nIm : nIm;
    // |n|*2^F >= d*2^W reduces to |n| >= 2d because W = F+1.
    preRe = ({1'b0, absRe} >= {dSum, 1'b0});
    preIm = ({1'b0, absIm} >= {dSum, 1'b0});
  end

  // Dividend is |n| shifted up by the fraction (plus half) bits; start from |n|>>1.
  complex_div_serial_div #(.DW(SUM_W), .QW(QBITS)) u_div_re (
    .clock(clk_i), .reset(rst_i), .load(loadDiv), .step(stepDiv),
    .remInit(absRe >> 1), .shiftIn({absRe[0], {(QBITS-1){1'b0}}}),
    .divisor(dSum), .quotient(qRe)
  );

  complex_div_serial_div #(.DW(SUM_W), .QW(QBITS)) u_div_im (
    .clock(clk_i), .reset(rst_i), .load(loadDiv), .step(stepDiv),
    .remInit(absIm >> 1), .shiftIn({absIm[0], {(QBITS-1){1'b0}}}),
    .divisor(dSum), .quotient(qIm)
  );

  assign finRe = finalize(qRe, negRe, preOvfRe);
  assign finIm = finalize(qIm, negIm, preOvfIm);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state and divider control.
  always_comb begin
    nextState = state;
    loadDiv   = 1'b0;
    stepDiv   = 1'b0;
    case (state)
      IDLE: if (in_valid_i) nextState = LOAD;
      LOAD: begin
        loadDiv   = 1'b1;
        nextState = DIV;
      end
      DIV: begin
        stepDiv = 1'b1;
        if (count == '0) nextState = DONE;
      end
      DONE: if (out_ready_i) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath. A zero divisor passes through one empty DIV cycle so its result
  // timing is fixed at two cycles and it shares the final capture path.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aRe <= '0; aIm <= '0; bRe <= '0; bIm <= '0;
      count <= '0;
      negRe <= 1'b0; negIm <= 1'b0;
      preOvfRe <= 1'b0; preOvfIm <= 1'b0; zeroDiv <= 1'b0;
      cRe <= '0; cIm <= '0; divZeroR <= 1'b0; ovfR <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid_i) begin
          aRe <= a_re_i; aIm <= a_im_i; bRe <= b_re_i; bIm <= b_im_i;
        end
        LOAD: begin
          zeroDiv  <= (dSum == '0);
          negRe    <= nRe[SUM_W-1];
          negIm    <= nIm[SUM_W-1];
          preOvfRe <= preRe;
          preOvfIm <= preIm;
          count    <= (dSum == '0) ? '0 : CNT_W'(QBITS - 1);
        end
        DIV: begin
          if (count != '0) begin
            count <= count - CNT_W'(1);
          end else begin
            cRe      <= zeroDiv ? '0 : finRe[W-1:0];
            cIm      <= zeroDiv ? '0 : finIm[W-1:0];
            divZeroR <= zeroDiv;
            ovfR     <= !zeroDiv && (finRe[W] || finIm[W]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);
  assign c_re_o      = cRe;
  assign c_im_o      = cIm;
  assign div_zero_o  = divZeroR;
  assign ovf_o       = ovfR;

endmodule
